// File: rtl/gsm_egress_sched.sv
// Packet-granular round-robin scheduler for one egress read port of the gsm shared cell buffer.
// Grants one descriptor queue at a time and issues one cell read per available slot until the packet ends.
module gsm_egress_sched #(
  parameter int NUM_REQ = 4,
  parameter int LWIDTH  = 3,
  parameter int SWIDTH  = $clog2(NUM_REQ)
) (
  input  logic                      clk_80M,
  input  logic                      clr_80M,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*LWIDTH-1:0] i_req_len,
  input  logic                      i_rd_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [SWIDTH-1:0]         o_rd_sel,
  output logic                      o_rd_en,
  output logic                      o_sop,
  output logic                      o_eop,
  output logic [NUM_REQ-1:0]        o_pop,
  output logic                      o_len_err,
  output logic                      o_busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [SWIDTH-1:0]   sel_q, last_q;
  logic [LWIDTH-1:0]   rem_q;
  logic                first_q, len_err_q;

  logic [SWIDTH-1:0]   idx, win;
  logic                win_vld;
  logic [LWIDTH-1:0]   win_len;
  logic                rd_en, eop;

  // Round-robin scan starting one past the last completed queue, wrapping modulo NUM_REQ.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = SWIDTH'(32'(last_q) + i);
      if (!win_vld && i_req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign win_len = i_req_len[win*LWIDTH +: LWIDTH];

  // State register
  always_ff @(posedge clk_80M) begin
    if (clr_80M) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = XFER;
      XFER:    if (eop)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; read strobes are combinational from registered state and the slot input
  always_comb begin
    rd_en     = (state_q == XFER) && i_rd_ready && !clr_80M;
    eop       = rd_en && (rem_q == LWIDTH'(1));
    o_rd_en   = rd_en;
    o_sop     = rd_en && first_q;
    o_eop     = eop;
    o_pop     = eop ? grant_q : '0;
    o_busy    = (state_q == XFER);
    o_grant   = grant_q;
    o_rd_sel  = sel_q;
    o_len_err = len_err_q;
  end

  // Grant, remaining-cell count and round-robin pointer
  always_ff @(posedge clk_80M) begin
    if (clr_80M) begin
      grant_q   <= '0;
      sel_q     <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      len_err_q <= 1'b0;
      last_q    <= SWIDTH'(NUM_REQ - 1);
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q   <= NUM_REQ'(1) << win;
            sel_q     <= win;
            // A zero-length descriptor still occupies one cell so it can be popped
            rem_q     <= (win_len == '0) ? LWIDTH'(1) : win_len;
            first_q   <= 1'b1;
            len_err_q <= (win_len == '0);
          end
        end
        XFER: begin
          if (rd_en) begin
            rem_q   <= rem_q - LWIDTH'(1);
            first_q <= 1'b0;
          end
          if (eop) begin
            last_q  <= sel_q;
            grant_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gsm_egress_sched.md
# gsm_egress_sched

Packet-granular round-robin scheduler that shares one egress read port of a gsm unit's shared cell buffer among NUM_REQ per-port descriptor queues. It sits between the egress descriptor queues and the shared-memory read datapath in the 80 MHz domain. For each winning queue it issues one cell read per available read slot until the whole packet has been read, then pops that queue's head descriptor.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting egress queues (power of two, ≥2)
- LWIDTH, 3, packet length field width in 16-byte cells (legal lengths 1..2^LWIDTH-1)
- SWIDTH, clogb(NUM_REQ), width of o_rd_sel

Ports:
- clk_80M  in  1  sole clock
- clr_80M  in  1  reset; synchronous, active-high
- i_req  in  NUM_REQ  bit k=1: queue k holds a head packet
- i_req_len  in  NUM_REQ*LWIDTH  head packet length of queue k in bits [(k+1)*LWIDTH-1 : k*LWIDTH]; valid while i_req[k]=1
- i_rd_ready  in  1  read slot available this cycle
- o_grant  out  NUM_REQ  one-hot registered grant; all-zero when idle
- o_rd_sel  out  SWIDTH  binary index of the granted queue
- o_rd_en  out  1  cell read issued this cycle
- o_sop  out  1  first cell of a packet; qualified by o_rd_en
- o_eop  out  1  last cell of a packet; qualified by o_rd_en
- o_pop  out  NUM_REQ  one-cycle pulse that dequeues the granted head descriptor
- o_len_err  out  1  one-cycle pulse when a zero-length packet is granted
- o_busy  out  1  state is XFER

## Operation
- Two states: IDLE and XFER.
- IDLE:
  - If i_req is non-zero, select the first set bit scanning from (last+1) mod NUM_REQ upward with wrap-around.
  - Register o_grant and o_rd_sel. Load rem = i_req_len of the winner; if that length is 0, load rem = 1 and pulse o_len_err on the next cycle.
  - Set the first flag and move to XFER.
  - If i_req is zero, stay in IDLE.
- XFER:
  - o_rd_en = i_rd_ready & ~clr_80M. This is combinational from registered state.
  - o_sop = o_rd_en & first. o_eop = o_rd_en & (rem==1).
  - On each o_rd_en, rem decrements and first clears.
  - A cycle with i_rd_ready=0 leaves all state unchanged. The grant is held indefinitely.
- Packet completion: on the o_eop cycle, o_pop[granted] pulses in the same cycle. At the clock edge, last is set to the granted index, o_grant clears, and the state returns to IDLE.
- The length is latched at grant. Later changes to i_req or i_req_len of the granted queue are ignored until pop.
- Requests from non-granted queues are ignored during XFER.
- A single-cell packet (len 1, or len 0) has o_sop and o_eop high on the same cycle.
- Width rule: rem is LWIDTH bits and never underflows, because it decrements only while rem≥1.

## Timing
- Reset values: o_grant=0, o_rd_sel=0, o_rd_en=0, o_sop=0, o_eop=0, o_pop=0, o_len_err=0, o_busy=0. Internally state=IDLE, rem=0, last=NUM_REQ-1, so queue 0 has first priority.
- Request to first read: i_req sampled in IDLE at edge N → grant visible in cycle N+1 → first o_rd_en possible in cycle N+1.
- Packet duration: len cells with i_rd_ready held high, plus one IDLE arbitration cycle between packets. Peak efficiency is len/(len+1).
- Descriptor update: o_pop at cycle M; the queue updates at edge M. The arbiter next samples i_req in IDLE at cycle M+1, so it always sees the updated head.
- Reset mid-packet:
  - o_rd_en is forced to 0 during any cycle in which clr_80M=1.
  - No o_pop is issued for the aborted packet; the descriptor stays queued.
  - After reset, state returns to the reset values above.
- Clear and eop in the same cycle: reset wins, and no pop is issued.

## Test plan
- Reset, then i_req=4'b1111 with lengths {q0:3, q1:1, q2:2, q3:7} and i_rd_ready=1 → grant order 0,1,2,3; read bursts of 3,1,2,7 cells; one pop per queue on its eop; 17 cycles total including 4 IDLE cycles.
- q0 only, len 4, i_rd_ready toggling 1,0,1,0… → 4 o_rd_en spread over 7 cycles; o_sop on the first read, o_eop and o_pop[0] on the fourth; o_grant=4'b0001 held throughout.
- Fairness: i_req=4'b0101 held continuously, all lengths 2 → grants alternate 0,2,0,2; neither queue is served twice in a row.
- q1 len 0 → exactly one cell with o_sop=o_eop=1, o_len_err pulses once, o_pop[1] pulses.
- Reset mid-packet: clr_80M asserted after 2 of 5 cells of q2 → o_rd_en=0 in the reset cycle, no o_pop[2]. After reset, with i_req=4'b0110, the next grant is q1, because the scan starts from queue 0.
- Single requester q3 len 7, i_req held high → 7 consecutive reads, 1 IDLE cycle, 7 more reads; o_pop[3] pulses on each eop.
